// File: rtl/bus_pkg.sv
// Shared definitions for the two-master simpleBUS arbiter: data width,
// default burst limit and the arbiter state encoding.
package bus_pkg;

    localparam int BUS_W         = 8;
    localparam int MAX_BURST_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t OWN0 = 2'd1;
    localparam state_t OWN1 = 2'd2;

    // Terminal value of the 4-bit burst counter for a given burst length.
    function automatic logic [3:0] burst_limit(input int max_burst);
        return 4'(max_burst - 1);
    endfunction

endpackage

// File: rtl/mux2_8bits.sv
// Two-input, bus-width data multiplexer: y = s ? b : a.
module mux2_8bits
    import bus_pkg::*;
(
    input  logic [BUS_W-1:0] a,
    input  logic [BUS_W-1:0] b,
    input  logic             s,
    output logic [BUS_W-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared 8-bit simpleBUS.
// Owner selection with a burst limit so a contended owner cannot hold the
// bus forever; the registered select steers mux2_8bits onto bus_data.
// Optional feature macro: BUS_ARB_RR_EN
//   defined     -> round-robin tie-break in IDLE (the master that did not
//                  own the bus last wins)
//   not defined -> fixed priority, M0 wins every IDLE tie
// Burst-limit preemption is active in both builds.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [BUS_W-1:0] d0,
    input  logic [BUS_W-1:0] d1,
    output logic             grant0,
    output logic             grant1,
    output logic             sel,
    output logic [BUS_W-1:0] bus_data,
    output logic             bus_valid
);

    localparam logic [3:0] LIMIT = burst_limit(MAX_BURST);

    state_t     state;
    state_t     state_next;
    logic [3:0] burst_cnt;
    logic       at_limit;
    logic       tie_to_m1;

    assign at_limit = (burst_cnt == LIMIT);

`ifdef BUS_ARB_RR_EN
    logic last;

    assign tie_to_m1 = ~last;

    // Round-robin pointer: remembers which master was granted most recently.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (state_next == OWN0 && state != OWN0) begin
            last <= 1'b0;
        end else if (state_next == OWN1 && state != OWN1) begin
            last <= 1'b1;
        end
    end
`else
    assign tie_to_m1 = 1'b0;
`endif

    // Next owner: request arbitration in IDLE, handoff/release/preemption when owned.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = tie_to_m1 ? OWN1 : OWN0;
                end else if (req0) begin
                    state_next = OWN0;
                end else if (req1) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_next = req1 ? OWN1 : IDLE;
                end else if (req1 && at_limit) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_next = req0 ? OWN0 : IDLE;
                end else if (req0 && at_limit) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, registered grants/select and the saturating burst counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant0    <= 1'b0;
            grant1    <= 1'b0;
            sel       <= 1'b0;
            burst_cnt <= 4'd0;
        end else begin
            state  <= state_next;
            grant0 <= (state_next == OWN0);
            grant1 <= (state_next == OWN1);
            if (state_next == OWN0) begin
                sel <= 1'b0;
            end else if (state_next == OWN1) begin
                sel <= 1'b1;
            end
            if (state_next != state) begin
                burst_cnt <= 4'd0;
            end else if (state != IDLE && !at_limit) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end

    assign bus_valid = (grant0 & req0) | (grant1 & req1);

    mux2_8bits u_mux (
        .a (d0),
        .b (d1),
        .s (sel),
        .y (bus_data)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a table of directed per-cycle vectors,
// a few hand-written multi-cycle sequences, then randomized requests checked
// against an ownership model written in terms of owner / cycles held.
// Honours BUS_ARB_RR_EN the same way as the design.
module tb_bus_arbiter;

    localparam int MAX_BURST = 4;
`ifdef BUS_ARB_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;
    logic       grant0;
    logic       grant1;
    logic       sel;
    logic [7:0] bus_data;
    logic       bus_valid;

    int n_compared = 0;
    int n_mismatched = 0;

    bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .d0        (d0),
        .d1        (d1),
        .grant0    (grant0),
        .grant1    (grant1),
        .sel       (sel),
        .bus_data  (bus_data),
        .bus_valid (bus_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       r0;
        logic       r1;
        logic [7:0] a;
        logic [7:0] b;
        logic       g0;
        logic       g1;
        logic       s;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: who owns the bus and for how many cycles.
    int m_owner;
    int m_held;
    int m_last;
    bit m_sel;

    task automatic add_vec(input logic rst, input logic r0, input logic r1,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic g0, input logic g1, input logic s, input logic v);
        vec_t t;
        t = '{rst: rst, r0: r0, r1: r1, a: a, b: b, g0: g0, g1: g1, s: s, v: v};
        vecs.push_back(t);
    endtask

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic g0, input logic g1,
                             input logic s, input logic v, input logic [7:0] y);
        check_output({tag, ".grant0"}, {7'd0, grant0}, {7'd0, g0});
        check_output({tag, ".grant1"}, {7'd0, grant1}, {7'd0, g1});
        check_output({tag, ".sel"}, {7'd0, sel}, {7'd0, s});
        check_output({tag, ".bus_valid"}, {7'd0, bus_valid}, {7'd0, v});
        check_output({tag, ".bus_data"}, bus_data, y);
    endtask

    task automatic apply_stimulus(input logic rst, input logic r0, input logic r1,
                                  input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        reset = rst;
        req0  = r0;
        req1  = r1;
        d0    = a;
        d1    = b;
    endtask

    task automatic model_step(input logic rst, input logic r0, input logic r1);
        bit req[2];
        int winner;
        int other;
        req[0] = r0;
        req[1] = r1;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 1;
            m_sel   = 1'b0;
        end else begin
            if (m_owner < 0) begin
                winner = -1;
                if (r0 && r1) winner = RR_BUILD ? (1 - m_last) : 0;
                else if (r0) winner = 0;
                else if (r1) winner = 1;
                if (winner >= 0) begin
                    m_owner = winner;
                    m_held  = 1;
                    m_last  = winner;
                end
            end else begin
                other = 1 - m_owner;
                if (!req[m_owner]) begin
                    if (req[other]) begin
                        m_owner = other;
                        m_held  = 1;
                        m_last  = other;
                    end else begin
                        m_owner = -1;
                        m_held  = 0;
                    end
                end else if (req[other] && m_held >= MAX_BURST) begin
                    m_owner = other;
                    m_held  = 1;
                    m_last  = other;
                end else begin
                    m_held++;
                end
            end
            if (m_owner >= 0) m_sel = (m_owner == 1);
        end
    endtask

    initial begin
        logic       r0;
        logic       r1;
        logic       rst;
        logic [7:0] a;
        logic [7:0] b;
        logic       eg0;
        logic       eg1;
        logic       ev;

        // Reset with all inputs high, then IDLE.
        add_vec(1, 1, 1, 8'hFF, 8'hFF, 0, 0, 0, 0);
        add_vec(1, 1, 1, 8'hFF, 8'hFF, 0, 0, 0, 0);
        add_vec(0, 0, 0, 8'hA5, 8'h3C, 0, 0, 0, 0);
        // Simultaneous requests from IDLE: M0 first, 4-cycle bursts alternate.
        for (int i = 0; i < 4; i++) add_vec(0, 1, 1, 8'hA5, 8'h3C, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) add_vec(0, 1, 1, 8'hA5, 8'h3C, 0, 1, 1, 1);
        add_vec(0, 1, 1, 8'hA5, 8'h3C, 1, 0, 0, 1);
        // Direct handoff to M1, then both release: IDLE with sel kept at 1.
        add_vec(0, 0, 1, 8'hA5, 8'h3C, 0, 1, 1, 1);
        add_vec(0, 0, 0, 8'hA5, 8'h3C, 0, 0, 1, 0);
        add_vec(0, 0, 0, 8'h11, 8'h22, 0, 0, 1, 0);
        // Reset while M1 owns the bus; M0 wins the first tie afterwards.
        add_vec(0, 0, 1, 8'hA5, 8'h3C, 0, 1, 1, 1);
        add_vec(1, 1, 1, 8'hA5, 8'h3C, 0, 0, 0, 0);
        add_vec(0, 1, 1, 8'hA5, 8'h3C, 1, 0, 0, 1);
        // M0 owned last: tie goes to M1 with round-robin, to M0 with fixed priority.
        add_vec(0, 0, 0, 8'h5A, 8'hC3, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add_vec(0, 1, 1, 8'h5A, 8'hC3, !RR_BUILD, RR_BUILD, RR_BUILD, 1);
        add_vec(0, 1, 1, 8'h5A, 8'hC3, RR_BUILD, !RR_BUILD, !RR_BUILD, 1);
        add_vec(0, 0, 0, 8'h5A, 8'hC3, 0, 0, !RR_BUILD, 0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].s, vecs[i].v,
                      vecs[i].s ? vecs[i].b : vecs[i].a);
        end

        // Long uncontended hold by M0, then M1 arrives against a saturated counter.
        apply_stimulus(1, 0, 0, 8'hA5, 8'h3C);
        apply_stimulus(1, 0, 0, 8'hA5, 8'h3C);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 8'hA5, 8'h3C);
        apply_stimulus(0, 1, 0, 8'hA5, 8'h3C);
        @(posedge clk);
        #1;
        check_all("solo.first", 1, 0, 0, 1, 8'hA5);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(0, 1, 0, 8'hA5, 8'h3C);
            @(posedge clk);
            #1;
            check_all($sformatf("solo.hold%0d", i), 1, 0, 0, 1, 8'hA5);
        end
        apply_stimulus(0, 1, 1, 8'hA5, 8'h3C);
        @(posedge clk);
        #1;
        check_all("solo.preempt", 0, 1, 1, 1, 8'h3C);
        // M1 releases while M0 waits: valid drops at once, grant moves on the edge.
        apply_stimulus(0, 1, 0, 8'hA5, 8'h3C);
        #1;
        check_output("release.valid_comb", {7'd0, bus_valid}, 8'd0);
        @(posedge clk);
        #1;
        check_all("release.handoff", 1, 0, 0, 1, 8'hA5);

        // Randomized requests against the ownership model.
        apply_stimulus(1, 0, 0, 8'h00, 8'h00);
        model_step(1, 0, 0);
        @(posedge clk);
        r0 = 0;
        r1 = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) r0 = ~r0;
            if ($urandom_range(3) == 0) r1 = ~r1;
            rst = ($urandom_range(63) == 0);
            a = 8'($urandom);
            b = 8'($urandom);
            apply_stimulus(rst, r0, r1, a, b);
            model_step(rst, r0, r1);
            @(posedge clk);
            #1;
            eg0 = (m_owner == 0);
            eg1 = (m_owner == 1);
            ev  = (eg0 && r0) || (eg1 && r1);
            check_all($sformatf("rand%0d", i), eg0, eg1, m_sel, ev, m_sel ? b : a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
